if_id_skid_stage: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID pipeline register.
- Carries instruction, PC and PC+4 from fetch to decode using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so fetch never sees a combinational path from decode stall logic.
- Supports a flush (branch/jump redirect) that kills all held entries and presents a NOP bubble.

---
 rtl/if_id_skid_stage.sv | 200 ++++++++++++++++++++
 tb/tb_if_id_skid_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: elastic IF/ID pipeline register with a 2-entry skid buffer.
// Carries instruction, PC and PC+4 from fetch to decode over valid/ready.
// in_ready comes straight from a flop, so decode stall logic never reaches
// fetch combinationally. flush empties the stage and presents a NOP bubble.
// Optional build macro: IF_ID_SKID_STATS_EN adds stall_cycles / flush_kills
// saturating counters.
module if_id_skid_stage #(
  parameter int                 INSTR_W      = 32,
  parameter int                 ADDR_W       = 64,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(32'h00000013)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [ADDR_W-1:0]  pcplus4_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pcplus4_out
`ifdef IF_ID_SKID_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_kills
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pcplus4;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Empty entries always hold this value, so the outputs need no masking.
  localparam beat_t BUBBLE_BEAT = '{instr:   BUBBLE_INSTR,
                                    pc:      {ADDR_W{1'b0}},
                                    pcplus4: {ADDR_W{1'b0}}};

  state_e state_q, state_d;
  beat_t  main_q,  main_d;
  beat_t  skid_q,  skid_d;
  logic   in_ready_q,  in_ready_d;
  logic   out_valid_q, out_valid_d;

  beat_t  in_beat_s;
  logic   accept_s;
  logic   drain_s;

  assign in_beat_s = '{instr: instr_in, pc: pc_in, pcplus4: pcplus4_in};
  assign accept_s  = in_valid && in_ready_q;
  assign drain_s   = out_valid_q && out_ready;

  // Next-state and next-payload selection; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_BEAT;
      skid_d  = BUBBLE_BEAT;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_d  = in_beat_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_d = in_beat_s;
          end else if (accept_s) begin
            state_d = ST_TWO;
            skid_d  = in_beat_s;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_BEAT;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_BEAT;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_BEAT;
          skid_d  = BUBBLE_BEAT;
        end
      endcase
    end
  end

  // Handshake flags are precomputed from the next state so both leave flops.
  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_BEAT;
      skid_q      <= BUBBLE_BEAT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign instr_out   = main_q.instr;
  assign pc_out      = main_q.pc;
  assign pcplus4_out = main_q.pcplus4;

`ifdef IF_ID_SKID_STATS_EN
  // Saturating add of a small increment to a 32-bit counter.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'b0, b};
    if (sum[32]) begin
      sat_add = 32'hFFFF_FFFF;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_kills_q,  flush_kills_d;
  logic [1:0]  held_cnt_s;

  // Number of valid entries currently held (discarded if a flush hits now).
  always_comb begin
    case (state_q)
      ST_EMPTY: held_cnt_s = 2'd0;
      ST_ONE:   held_cnt_s = 2'd1;
      ST_TWO:   held_cnt_s = 2'd2;
      default:  held_cnt_s = 2'd0;
    endcase
  end

  // Counter updates: stalls are back-pressured valid cycles, kills are flushed entries.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_kills_d  = flush_kills_q;
    if (out_valid_q && !out_ready) begin
      stall_cycles_d = sat_add(stall_cycles_q, 2'd1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush) begin
      flush_kills_d = sat_add(flush_kills_q, held_cnt_s);
    end else begin
      flush_kills_d = flush_kills_q;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_kills_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_kills_q  <= flush_kills_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_kills  = flush_kills_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: directed plus randomized bench for if_id_skid_stage,
// checked against a queue-based model of a 2-deep FIFO stage.
module tb_if_id_skid_stage;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam logic [31:0] BUBBLE = 32'h00000013;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr_in;
  logic [63:0]       pc_in;
  logic [63:0]       pcplus4_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr_out;
  logic [63:0]       pc_out;
  logic [63:0]       pcplus4_out;
`ifdef IF_ID_SKID_STATS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_kills;
`endif

  if_id_skid_stage #(
    .INSTR_W(INSTR_W),
    .ADDR_W(ADDR_W),
    .BUBBLE_INSTR(BUBBLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr_in(instr_in),
    .pc_in(pc_in),
    .pcplus4_in(pcplus4_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pcplus4_out(pcplus4_out)
`ifdef IF_ID_SKID_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_kills(flush_kills)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc4;
  } beat_t;

  // Reference model: the stage is a FIFO of capacity 2 whose ready flag is
  // "fewer than two entries held", sampled after each clock edge.
  beat_t       mq[$];
  bit          m_ready = 1'b1;
  int unsigned m_stall = 0;
  int unsigned m_kills = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit drn;
    beat_t b;
    if (reset) begin
      mq.delete();
      m_ready = 1'b1;
      m_stall = 0;
      m_kills = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
        m_kills = m_kills + mq.size();
        mq.delete();
      end else begin
        acc = in_valid && m_ready;
        drn = (mq.size() > 0) && out_ready;
        if (drn) void'(mq.pop_front());
        if (acc) begin
          b.instr = instr_in;
          b.pc    = pc_in;
          b.pc4   = pcplus4_in;
          mq.push_back(b);
        end
      end
      m_ready = (mq.size() < 2);
    end
  endtask

  task automatic check_model();
    if (mq.size() > 0) begin
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("instr_out", 64'(instr_out), 64'(mq[0].instr));
      chk("pc_out", pc_out, mq[0].pc);
      chk("pcplus4_out", pcplus4_out, mq[0].pc4);
    end else begin
      chk("out_valid", 64'(out_valid), 64'd0);
      chk("instr_out_bubble", 64'(instr_out), 64'(BUBBLE));
      chk("pc_out_zero", pc_out, 64'd0);
      chk("pcplus4_out_zero", pcplus4_out, 64'd0);
    end
    chk("in_ready", 64'(in_ready), 64'(m_ready));
`ifdef IF_ID_SKID_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("flush_kills", 64'(flush_kills), 64'(m_kills));
`endif
  endtask

  task automatic drive(input bit rst, input bit fl, input bit iv, input bit ordy,
                       input logic [63:0] pc, input logic [31:0] instr);
    reset      = rst;
    flush      = fl;
    in_valid   = iv;
    out_ready  = ordy;
    pc_in      = pc;
    pcplus4_in = pc + 64'd4;
    instr_in   = instr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    cycle();
    cycle();

    // Idle after reset.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    cycle();
    cycle();
    chk("idle_instr", 64'(instr_out), 64'h13);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Full-throughput stream of 8 beats.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h1000 + 64'(4 * k), 32'hA000_0000 + 32'(k));
      cycle();
      chk("stream_pc", pc_out, 64'h1000 + 64'(4 * k));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
    cycle();

    // Fill both entries under back-pressure, then release.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h2000, 32'hB000_0000);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h2004, 32'hB000_0001);
    cycle();
    chk("two_ready", 64'(in_ready), 64'd0);
    chk("two_pc", pc_out, 64'h2000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
    cycle();
    chk("drain1_pc", pc_out, 64'h2004);
    cycle();
    chk("drain2_valid", 64'(out_valid), 64'd0);
    chk("drain2_ready", 64'(in_ready), 64'd1);

    // Flush while holding two entries, with a beat offered.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h2100, 32'hC000_0000);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h2104, 32'hC000_0001);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h3000, 32'hD000_0000);
    cycle();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc", pc_out, 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
`ifdef IF_ID_SKID_STATS_EN
    chk("flush_kills_two", 64'(flush_kills), 64'd2);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
    cycle();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), {$urandom, $urandom}, $urandom);
      cycle();
    end

    // Reset and flush together while one entry is held.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h4000, 32'hE000_0000);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h4004, 32'hE000_0001);
    cycle();
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    chk("rst_flush_instr", 64'(instr_out), 64'h13);
    chk("rst_flush_ready", 64'(in_ready), 64'd1);
`ifdef IF_ID_SKID_STATS_EN
    chk("rst_stall_zero", 64'(stall_cycles), 64'd0);
    chk("rst_kills_zero", 64'(flush_kills), 64'd0);
`endif

    // Hold one beat under back-pressure for 5 cycles.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h5000, 32'hF000_0000);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_pc", pc_out, 64'h5000);
      chk("hold_pc4", pcplus4_out, 64'h5004);
      chk("hold_instr", 64'(instr_out), 64'hF000_0000);
    end
`ifdef IF_ID_SKID_STATS_EN
    chk("stall_five", 64'(stall_cycles), 64'd5);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 32'd0);
    cycle();
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
